// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
//
// Purpose: groups the fetch request, data request and memory port signals
// shared by mem_port_arbiter and its environment.
// Modports:
//   slave  - arbiter view. Request and memory read data are inputs.
//            Acks, read data, memory controls and busy are outputs.
//   master - environment view. This is the mirror image of the slave modport.
// Signals:
//   i_req/i_addr/i_ack/i_rdata                 instruction-fetch port
//   d_req/d_we/d_addr/d_wdata/d_ack/d_rdata    load/store port
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata unified memory port
//   busy                                       arbiter not idle

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter and sequencer for one unified memory port
//
// Purpose: grants the memory port to either the fetch path or the data path.
// It holds the memory inputs for MEM_LAT cycles and then samples mem_rdata.
// It then pulses the winner's ack for one cycle, and only then returns to idle.
// Ports:
//   clk  - clock; all logic updates on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - mem_port_arbiter_if.slave bundle (requests, acks, read data, memory port, busy)
// Parameters: ADDR_W, DATA_W, MEM_LAT (memory hold cycles, >= 1)
// Build option: ARB_ROUND_ROBIN_EN
//   When defined, the arbiter alternates between the two sides whenever both request.
//   When undefined, a data request always beats a fetch request.

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              grant_d;     // 1 = current access belongs to the data side
    logic              i_ack_r;
    logic              d_ack_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    logic any_req;
    logic pick_d;

    assign any_req = bus.i_req | bus.d_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Reset value 0 means "fetch was granted last".
    // This makes the first conflict after reset go to the data side.
    logic last_grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_d <= 1'b0;
        end else if (state == S_IDLE && any_req) begin
            last_grant_d <= pick_d;
        end
    end

    // A lone request always wins.
    // On a conflict, the side that was not granted last wins.
    always_comb begin
        pick_d = bus.d_req && (!bus.i_req || !last_grant_d);
    end
`else
    always_comb begin
        pick_d = bus.d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            grant_d     <= 1'b0;
            i_ack_r     <= 1'b0;
            d_ack_r     <= 1'b0;
            i_rdata_r   <= '0;
            d_rdata_r   <= '0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_d     <= pick_d;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= pick_d & bus.d_we;
                        mem_addr_r  <= pick_d ? bus.d_addr : bus.i_addr;
                        mem_wdata_r <= pick_d ? bus.d_wdata : '0;
                        cnt         <= CNT_W'(MEM_LAT - 1);
                        state       <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // The final ACCESS cycle samples memory and raises the ack.
                    // The ack and the new read data are therefore both visible in DONE.
                    if (cnt == '0) begin
                        if (grant_d) begin
                            if (!mem_we_r) begin
                                d_rdata_r <= bus.mem_rdata;
                            end
                            d_ack_r <= 1'b1;
                        end else begin
                            i_rdata_r <= bus.mem_rdata;
                            i_ack_r   <= 1'b1;
                        end
                        mem_en_r <= 1'b0;
                        mem_we_r <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    i_ack_r <= 1'b0;
                    d_ack_r <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.i_ack     = i_ack_r;
    assign bus.d_ack     = d_ack_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    logic [31:0] mem0 [0:255];
    logic [31:0] mem1 [0:255];

    always @(posedge clk) begin
        if (b0.mem_en && b0.mem_we) mem0[b0.mem_addr[9:2]] <= b0.mem_wdata;
        if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[9:2]] <= b1.mem_wdata;
    end
    assign b0.mem_rdata = mem0[b0.mem_addr[9:2]];
    assign b1.mem_rdata = mem1[b1.mem_addr[9:2]];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word1(input int j);
        return 32'h5A000000 ^ (j * 32'h00010203);
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
    endtask

    // Runs one isolated access on the MEM_LAT=2 instance.
    // Every cycle from grant to idle is checked.
    // rexp is the expected read data for a read.
    // For a store, rexp is the value d_rdata must keep.
    task automatic access0(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rexp, input string tag);
        if (is_d) begin
            b0.d_req = 1'b1; b0.d_we = we; b0.d_addr = addr; b0.d_wdata = wdata;
        end else begin
            b0.i_req = 1'b1; b0.i_addr = addr;
        end
        tick;
        check({tag, " en c1"},   b0.mem_en, 1);
        check({tag, " we c1"},   b0.mem_we, is_d & we);
        check({tag, " addr c1"}, b0.mem_addr, addr);
        check({tag, " busy c1"}, b0.busy, 1);
        if (we) check({tag, " wdata c1"}, b0.mem_wdata, wdata);
        tick;
        check({tag, " en c2"},   b0.mem_en, 1);
        check({tag, " addr c2"}, b0.mem_addr, addr);
        check({tag, " ack c2"},  b0.i_ack | b0.d_ack, 0);
        if (we) check({tag, " wdata c2"}, b0.mem_wdata, wdata);
        tick;
        check({tag, " ack"},     is_d ? b0.d_ack : b0.i_ack, 1);
        check({tag, " ack oth"}, is_d ? b0.i_ack : b0.d_ack, 0);
        check({tag, " en done"}, b0.mem_en, 0);
        check({tag, " rdata"},   is_d ? b0.d_rdata : b0.i_rdata, rexp);
        b0.i_req = 1'b0;
        b0.d_req = 1'b0;
        tick;
        check({tag, " busy idle"}, b0.busy, 0);
        check({tag, " ack idle"},  b0.i_ack | b0.d_ack, 0);
    endtask

    bit exp_d [4];
    int cyc;
    bit got;
    bit ack_seen;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int j = 0; j < 256; j++) begin
            mem0[j] = 32'h0;
            mem1[j] = word1(j);
        end
        mem0[8'h10] = 32'h8C010004;   // 0x40
        mem0[8'h08] = 32'h11112222;   // 0x20
        mem0[8'h20] = 32'h33334444;   // 0x80

        b0.i_req = 0; b0.i_addr = 0; b0.d_req = 0; b0.d_we = 0; b0.d_addr = 0; b0.d_wdata = 0;
        b1.i_req = 0; b1.i_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
        rst = 1'b1;
        tick; tick; tick;
        check("rst busy",  b0.busy, 0);
        check("rst en",    b0.mem_en, 0);
        check("rst we",    b0.mem_we, 0);
        check("rst addr",  b0.mem_addr, 0);
        check("rst wdata", b0.mem_wdata, 0);
        check("rst acks",  {b0.i_ack, b0.d_ack}, 0);
        check("rst irdat", b0.i_rdata, 0);
        check("rst drdat", b0.d_rdata, 0);
        rst = 1'b0;
        tick; tick;

        access0(1'b0, 1'b0, 32'h40,  32'h0,        32'h8C010004, "fetch");
        access0(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0,        "store");
        access0(1'b1, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, "load");

        // The fetch and the load are raised in the same cycle.
        do_reset;
        b0.i_req = 1; b0.i_addr = 32'h20;
        b0.d_req = 1; b0.d_we = 0; b0.d_addr = 32'h80;
        tick;
        check("conf addr1", b0.mem_addr, 32'h80);
        tick;
        tick;
        check("conf dack",  b0.d_ack, 1);
        check("conf iack0", b0.i_ack, 0);
        check("conf drd",   b0.d_rdata, 32'h33334444);
        b0.d_req = 0;
        tick;
        check("conf gap",   {b0.i_ack, b0.d_ack, b0.busy}, 0);
        tick;
        check("conf addr2", b0.mem_addr, 32'h20);
        tick;
        tick;
        check("conf iack",  b0.i_ack, 1);
        check("conf dack0", b0.d_ack, 0);
        check("conf ird",   b0.i_rdata, 32'h11112222);
        b0.i_req = 0;
        tick;

        // Both sides keep requesting for four grants.
        do_reset;
        b0.i_req = 1; b0.i_addr = 32'h20;
        b0.d_req = 1; b0.d_we = 0; b0.d_addr = 32'h80;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            got = 0;
            while (!got && cyc < 12) begin
                tick;
                cyc++;
                if (b0.i_ack || b0.d_ack) got = 1;
            end
            check($sformatf("order ack%0d", k),  got, 1);
            check($sformatf("order excl%0d", k), b0.i_ack & b0.d_ack, 0);
            check($sformatf("order side%0d", k), b0.d_ack, exp_d[k]);
            check($sformatf("order lat%0d", k),  cyc, (k == 0) ? 3 : 4);
        end
        b0.i_req = 0; b0.d_req = 0;
        tick; tick;

        // Reset lands in the second ACCESS cycle of a fetch.
        do_reset;
        b0.i_req = 1; b0.i_addr = 32'h40;
        tick;
        tick;
        check("abort en c2", b0.mem_en, 1);
        rst = 1'b1;
        tick;
        check("abort busy",  b0.busy, 0);
        check("abort en",    b0.mem_en, 0);
        check("abort we",    b0.mem_we, 0);
        check("abort addr",  b0.mem_addr, 0);
        check("abort acks",  {b0.i_ack, b0.d_ack}, 0);
        check("abort irdat", b0.i_rdata, 0);
        rst = 1'b0;
        b0.i_req = 0;
        ack_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (b0.i_ack || b0.d_ack) ack_seen = 1;
        end
        check("abort noack", ack_seen, 0);

        // MEM_LAT=1 instance: ten requests alternate between fetch and load.
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                b1.i_req = 1; b1.i_addr = 32'((k + 3) * 4);
            end else begin
                b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'((k + 3) * 4);
            end
            cyc = 0;
            got = 0;
            while (!got && cyc < 10) begin
                tick;
                cyc++;
                if (b1.i_ack || b1.d_ack) got = 1;
            end
            check($sformatf("lat1 ack%0d", k),  got, 1);
            check($sformatf("lat1 lat%0d", k),  cyc, 2);
            check($sformatf("lat1 side%0d", k), b1.d_ack, (k % 2 == 1));
            check($sformatf("lat1 data%0d", k),
                  (k % 2 == 0) ? b1.i_rdata : b1.d_rdata, word1(k + 3));
            b1.i_req = 0; b1.d_req = 0;
            tick;
            check($sformatf("lat1 idle%0d", k), b1.busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
